pupil_roi_ctrl: RTL and testbench
=================================

PUPIL_ROI_CTRL -- requirements
Module: pupil_roi_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- IMG_HDISP, 1280, active columns.
- IMG_VDISP, 720, active rows.
- MIN_SEP, 150, minimum column separation between pupils.
- MAX_JUMP, 64, maximum per-frame coordinate change while tracking.
- LOCK_FRAMES, 3, consecutive consistent frames needed to lock.
- LOST_FRAMES, 4, consecutive bad frames that drop lock.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- per_frame_vsync, in, 1: frame sync; the rising edge marks frame start.
- res_valid, in, 1: one-cycle pulse when projection results update.
- res_x1, res_x2, in, 11: measured pupil columns.
- res_y1, res_y2, in, 16: measured pupil rows.
- roi_x1, roi_x2, out, 11: ROI centre columns.
- roi_y1, roi_y2, out, 16: ROI centre rows.
- roi_valid, out, 1: ROI active. 0 means the consumer searches the full frame.
- trk_state, out, 2: current state.
- track_lost, out, 1: one-cycle pulse when lock is dropped.
- lock_cnt, out, 3: consecutive-consistent counter.

Function
REQ-003 States SHALL be SEARCH=0, ACQUIRE=1, TRACK=2 and COAST=3. roi_valid=1 only in TRACK and COAST.

REQ-004 A result is "good" when all of the following hold:
- res_x1 != 0 and res_x2 != 0.
- |res_x1 - res_x2| >= MIN_SEP.
- res_x1 and res_x2 < IMG_HDISP.
- res_y1 and res_y2 < IMG_VDISP.

REQ-005 Before evaluation, the pair SHALL be sorted so that index 1 holds the smaller column.

REQ-006 A good result is "consistent" when each sorted coordinate differs from the stored candidate (SEARCH/ACQUIRE) or the current ROI (TRACK/COAST) by <= MAX_JUMP.

REQ-007 Differences SHALL be computed as unsigned absolute values at 1 bit wider than the operand; no wrap-around is permitted.

REQ-008 A "bad frame" is either of:
- a res_valid pulse carrying a non-good result, or
- a vsync rising edge with no res_valid since the previous vsync rising edge (missed result).

REQ-009 SEARCH transitions:
- A good result stores the candidate, sets lock_cnt=1, and moves to ACQUIRE.
- A bad frame stays in SEARCH.

REQ-010 ACQUIRE transitions:
- A consistent result stores the candidate and increments lock_cnt.
- When lock_cnt reaches LOCK_FRAMES, the ROI loads the candidate and the state moves to TRACK.
- A good but inconsistent result restarts the candidate with lock_cnt=1.
- A bad frame returns to SEARCH with lock_cnt=0.

REQ-011 TRACK transitions:
- A consistent result updates each ROI coordinate to (roi + res + 1) >> 1, computed in a widened intermediate.
- A bad or inconsistent frame moves to COAST with the ROI held and the miss counter set to 1.

REQ-012 COAST transitions:
- A consistent result applies the REQ-011 update, clears the miss counter, and returns to TRACK.
- Otherwise the miss counter increments.
- When the miss counter reaches LOST_FRAMES, the state moves to SEARCH, roi_valid=0, the ROI clears to 0, and track_lost pulses for exactly one cycle.

REQ-013 Outputs SHALL update exactly one clk after the triggering res_valid or vsync edge, and SHALL be held constant at all other times.

REQ-014 If res_valid and a vsync rising edge occur in the same cycle, the result SHALL be processed and the missed-result check SHALL be suppressed for that edge.

REQ-015 Vsync edge detection SHALL use one register stage. The first vsync rising edge after reset SHALL NOT count as a missed result.

Reset
REQ-016 Reset SHALL be asynchronous via rst_n low. It SHALL force:
- state=SEARCH,
- all roi_* and candidates to 0,
- roi_valid=0, track_lost=0, lock_cnt=0,
- the miss counter to 0,
- the seen-result flag to 0.

REQ-017 Reset asserted mid-frame SHALL take effect immediately. After release, operation resumes from SEARCH with no spurious track_lost.

Structure
REQ-018 A shared package pupil_track_pkg SHALL hold the state enum, IMG_HDISP/IMG_VDISP defaults and coordinate width constants.

REQ-019 One combinational sub-module, pupil_pair_check, SHALL perform the sort and the good/consistent evaluation. The FSM and registers SHALL reside in pupil_roi_ctrl.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Lock: three results (300,400)/(600,410), each with a one-frame vsync -> ACQUIRE lock_cnt 1,2, then TRACK with roi_valid=1 and roi=(300,400)/(600,410).
- Sort and smooth: in TRACK, result swapped as x1=620,x2=310 with y unchanged -> roi_x1=305, roi_x2=610.
- Loss: in TRACK, four frames with res_x2=0 -> COAST with miss 1..3, then SEARCH on the fourth, track_lost high for exactly 1 cycle, roi cleared.
- Missed result: in TRACK, two vsync rises with no res_valid -> COAST after the second edge; the next consistent result returns to TRACK.
- Separation and jump: result x1=300,x2=420 (sep 120) in SEARCH -> stays SEARCH. In ACQUIRE, a jump of 100 -> lock_cnt restarts at 1.
- Reset: rst_n low in COAST with miss=2 -> all outputs 0 the same cycle; the first vsync after release produces no state change.

Source files
------------

// File: rtl/pupil_track_pkg.sv
// pupil_track_pkg: shared state enum, image defaults, coordinate widths and pair helpers
//   pair_t    : one pupil pair (x1,y1)/(x2,y2)
//   pair_avg  : rounded midpoint of two pairs, computed one bit wider so nothing wraps
package pupil_track_pkg;
    typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2, COAST = 2'd3} trk_state_e;
    localparam int IMG_HDISP_DEF = 1280;
    localparam int IMG_VDISP_DEF = 720;
    localparam int X_W = 11;
    localparam int Y_W = 16;
    typedef struct packed {
        logic [X_W-1:0] x1;
        logic [X_W-1:0] x2;
        logic [Y_W-1:0] y1;
        logic [Y_W-1:0] y2;
    } pair_t;
    function automatic pair_t pair_avg(input pair_t a, input pair_t b);
        logic [X_W:0] sx1, sx2;
        logic [Y_W:0] sy1, sy2;
        sx1 = {1'b0, a.x1} + {1'b0, b.x1} + (X_W+1)'(1);
        sx2 = {1'b0, a.x2} + {1'b0, b.x2} + (X_W+1)'(1);
        sy1 = {1'b0, a.y1} + {1'b0, b.y1} + (Y_W+1)'(1);
        sy2 = {1'b0, a.y2} + {1'b0, b.y2} + (Y_W+1)'(1);
        pair_avg.x1 = sx1[X_W:1];
        pair_avg.x2 = sx2[X_W:1];
        pair_avg.y1 = sy1[Y_W:1];
        pair_avg.y2 = sy2[Y_W:1];
    endfunction
endpackage

// File: rtl/pupil_pair_check.sv
// pupil_pair_check: sorts a measured pupil pair by column and flags it good / consistent
//   res_i    : raw measured pair
//   ref_i    : reference pair (candidate or current ROI)
//   sorted_o : pair with the smaller column in slot 1
//   good_o   : pair is plausible on its own
//   cons_o   : pair is good and within MAX_JUMP of the reference on every coordinate
module pupil_pair_check
    import pupil_track_pkg::*;
#(
    parameter int IMG_HDISP = IMG_HDISP_DEF,
    parameter int IMG_VDISP = IMG_VDISP_DEF,
    parameter int MIN_SEP   = 150,
    parameter int MAX_JUMP  = 64
) (
    input  pair_t res_i,
    input  pair_t ref_i,
    output pair_t sorted_o,
    output logic  good_o,
    output logic  cons_o
);
    localparam logic [Y_W:0] HD_L  = (Y_W+1)'(IMG_HDISP);
    localparam logic [Y_W:0] VD_L  = (Y_W+1)'(IMG_VDISP);
    localparam logic [Y_W:0] SEP_L = (Y_W+1)'(MIN_SEP);
    localparam logic [Y_W:0] JMP_L = (Y_W+1)'(MAX_JUMP);
    // columns are zero-extended to row width so one absolute-difference helper serves both
    function automatic logic [Y_W:0] ad(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
        ad = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction
    pair_t s;
    always_comb begin
        s = res_i;
        if (res_i.x1 > res_i.x2) begin
            s.x1 = res_i.x2;
            s.x2 = res_i.x1;
            s.y1 = res_i.y2;
            s.y2 = res_i.y1;
        end
        sorted_o = s;
        good_o = (|s.x1) && (|s.x2)
              && (ad(Y_W'(s.x1), Y_W'(s.x2)) >= SEP_L)
              && ((Y_W+1)'(s.x1) < HD_L) && ((Y_W+1)'(s.x2) < HD_L)
              && ({1'b0, s.y1} < VD_L) && ({1'b0, s.y2} < VD_L);
        cons_o = good_o
              && (ad(Y_W'(s.x1), Y_W'(ref_i.x1)) <= JMP_L)
              && (ad(Y_W'(s.x2), Y_W'(ref_i.x2)) <= JMP_L)
              && (ad(s.y1, ref_i.y1) <= JMP_L)
              && (ad(s.y2, ref_i.y2) <= JMP_L);
    end
endmodule

// File: rtl/pupil_roi_ctrl.sv
// pupil_roi_ctrl: pupil-pair lock/track FSM producing a smoothed ROI for the projection search
//   per_frame_vsync, res_valid, res_* : frame sync and measured pupil pair
//   roi_*, roi_valid                  : ROI centres, valid in TRACK/COAST
//   trk_state, track_lost, lock_cnt   : tracker status
module pupil_roi_ctrl
    import pupil_track_pkg::*;
#(
    parameter int IMG_HDISP   = IMG_HDISP_DEF,
    parameter int IMG_VDISP   = IMG_VDISP_DEF,
    parameter int MIN_SEP     = 150,
    parameter int MAX_JUMP    = 64,
    parameter int LOCK_FRAMES = 3,
    parameter int LOST_FRAMES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           per_frame_vsync,
    input  logic           res_valid,
    input  logic [X_W-1:0] res_x1,
    input  logic [X_W-1:0] res_x2,
    input  logic [Y_W-1:0] res_y1,
    input  logic [Y_W-1:0] res_y2,
    output logic [X_W-1:0] roi_x1,
    output logic [X_W-1:0] roi_x2,
    output logic [Y_W-1:0] roi_y1,
    output logic [Y_W-1:0] roi_y2,
    output logic           roi_valid,
    output logic [1:0]     trk_state,
    output logic           track_lost,
    output logic [2:0]     lock_cnt
);
    localparam logic [2:0] LOCK_L = 3'(LOCK_FRAMES);
    localparam logic [2:0] LOST_L = 3'(LOST_FRAMES);
    trk_state_e state_q, state_d;
    logic [2:0] lock_q, lock_d, miss_q, miss_d;
    pair_t      cand_q, cand_d, roi_q, roi_d, res, srt;
    logic       lost_q, lost_d, vs_q, seen_q, armed_q;
    logic       good, cons, rise, miss_evt, bad;
    assign res      = '{x1: res_x1, x2: res_x2, y1: res_y1, y2: res_y2};
    assign rise     = per_frame_vsync & ~vs_q;
    // armed_q keeps the very first vsync edge after reset from counting as a missed result
    assign miss_evt = rise & ~res_valid & ~seen_q & armed_q;
    assign bad      = (res_valid & ~good) | miss_evt;
    pupil_pair_check #(
        .IMG_HDISP(IMG_HDISP),
        .IMG_VDISP(IMG_VDISP),
        .MIN_SEP  (MIN_SEP),
        .MAX_JUMP (MAX_JUMP)
    ) u_chk (
        .res_i   (res),
        .ref_i   ((state_q == TRACK || state_q == COAST) ? roi_q : cand_q),
        .sorted_o(srt),
        .good_o  (good),
        .cons_o  (cons)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEARCH;
            lock_q  <= '0;
            miss_q  <= '0;
            cand_q  <= '0;
            roi_q   <= '0;
            lost_q  <= 1'b0;
            vs_q    <= 1'b0;
            seen_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            miss_q  <= miss_d;
            cand_q  <= cand_d;
            roi_q   <= roi_d;
            lost_q  <= lost_d;
            vs_q    <= per_frame_vsync;
            seen_q  <= rise ? 1'b0 : (seen_q | res_valid);
            armed_q <= armed_q | rise;
        end
    end
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        miss_d  = miss_q;
        cand_d  = cand_q;
        roi_d   = roi_q;
        lost_d  = 1'b0;
        case (state_q)
            SEARCH: if (res_valid && good) begin
                cand_d  = srt;
                lock_d  = 3'd1;
                state_d = ACQUIRE;
            end
            ACQUIRE: if (res_valid && cons) begin
                cand_d = srt;
                lock_d = lock_q + 3'd1;
                if (lock_q + 3'd1 == LOCK_L) begin
                    roi_d   = srt;
                    state_d = TRACK;
                end
            end else if (res_valid && good) begin
                cand_d = srt;
                lock_d = 3'd1;
            end else if (bad) begin
                lock_d  = '0;
                state_d = SEARCH;
            end
            TRACK: if (res_valid && cons) begin
                roi_d = pair_avg(roi_q, srt);
            end else if (res_valid || miss_evt) begin
                miss_d  = 3'd1;
                state_d = COAST;
            end
            default: if (res_valid && cons) begin
                roi_d   = pair_avg(roi_q, srt);
                miss_d  = '0;
                state_d = TRACK;
            end else if (res_valid || miss_evt) begin
                miss_d = miss_q + 3'd1;
                if (miss_q + 3'd1 == LOST_L) begin
                    miss_d  = '0;
                    lock_d  = '0;
                    roi_d   = '0;
                    lost_d  = 1'b1;
                    state_d = SEARCH;
                end
            end
        endcase
    end
    always_comb begin
        roi_x1     = roi_q.x1;
        roi_x2     = roi_q.x2;
        roi_y1     = roi_q.y1;
        roi_y2     = roi_q.y2;
        roi_valid  = (state_q == TRACK) || (state_q == COAST);
        trk_state  = state_q;
        track_lost = lost_q;
        lock_cnt   = lock_q;
    end
endmodule

// File: tb/tb_pupil_roi_ctrl.sv
// tb_pupil_roi_ctrl: directed checks of lock, smoothing, loss, missed results, gating and reset
module tb_pupil_roi_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        per_frame_vsync = 1'b0;
    logic        res_valid = 1'b0;
    logic [10:0] res_x1 = '0, res_x2 = '0, roi_x1, roi_x2;
    logic [15:0] res_y1 = '0, res_y2 = '0, roi_y1, roi_y2;
    logic        roi_valid, track_lost;
    logic [1:0]  trk_state;
    logic [2:0]  lock_cnt;
    int          checks = 0;
    int          errors = 0;
    pupil_roi_ctrl dut (
        .clk(clk), .rst_n(rst_n), .per_frame_vsync(per_frame_vsync), .res_valid(res_valid),
        .res_x1(res_x1), .res_x2(res_x2), .res_y1(res_y1), .res_y2(res_y2),
        .roi_x1(roi_x1), .roi_x2(roi_x2), .roi_y1(roi_y1), .roi_y2(roi_y2),
        .roi_valid(roi_valid), .trk_state(trk_state), .track_lost(track_lost), .lock_cnt(lock_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask
    task automatic vsync();
        @(negedge clk) per_frame_vsync = 1'b1;
        repeat (3) @(negedge clk);
        per_frame_vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask
    task automatic result(input int x1, input int y1, input int x2, input int y2);
        @(negedge clk);
        res_x1 = 11'(x1); res_y1 = 16'(y1); res_x2 = 11'(x2); res_y2 = 16'(y2);
        res_valid = 1'b1;
        @(negedge clk) res_valid = 1'b0;
    endtask
    task automatic frame(input int x1, input int y1, input int x2, input int y2);
        vsync();
        result(x1, y1, x2, y2);
    endtask
    task automatic chk_roi(input string tag, input int x1, input int y1, input int x2, input int y2);
        chk({tag, "_x1"}, 32'(roi_x1), x1);
        chk({tag, "_y1"}, 32'(roi_y1), y1);
        chk({tag, "_x2"}, 32'(roi_x2), x2);
        chk({tag, "_y2"}, 32'(roi_y2), y2);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(trk_state), 0);
        chk("rst_valid", 32'(roi_valid), 0);
        chk("rst_lock", 32'(lock_cnt), 0);
        rst_n = 1'b1;
        frame(300, 400, 600, 410);
        chk("lock1_state", 32'(trk_state), 1);
        chk("lock1_cnt", 32'(lock_cnt), 1);
        chk("lock1_valid", 32'(roi_valid), 0);
        frame(300, 400, 600, 410);
        chk("lock2_cnt", 32'(lock_cnt), 2);
        frame(300, 400, 600, 410);
        chk("lock3_state", 32'(trk_state), 2);
        chk("lock3_valid", 32'(roi_valid), 1);
        chk_roi("lock3_roi", 300, 400, 600, 410);
        vsync();
        @(negedge clk);
        res_x1 = 11'd620; res_y1 = 16'd410; res_x2 = 11'd310; res_y2 = 16'd400;
        res_valid = 1'b1;
        #1 chk("hold_before_edge", 32'(roi_x1), 300);
        @(negedge clk) res_valid = 1'b0;
        chk("smooth_state", 32'(trk_state), 2);
        chk_roi("smooth_roi", 305, 400, 610, 410);
        for (int i = 1; i <= 3; i++) begin
            frame(300, 400, 0, 410);
            chk($sformatf("loss%0d_state", i), 32'(trk_state), 3);
            chk($sformatf("loss%0d_lost", i), 32'(track_lost), 0);
        end
        chk_roi("coast_hold_roi", 305, 400, 610, 410);
        frame(300, 400, 0, 410);
        chk("loss4_state", 32'(trk_state), 0);
        chk("loss4_lost", 32'(track_lost), 1);
        chk("loss4_valid", 32'(roi_valid), 0);
        chk_roi("loss4_roi", 0, 0, 0, 0);
        @(negedge clk);
        chk("loss4_lost_pulse", 32'(track_lost), 0);
        for (int i = 0; i < 3; i++) frame(300, 400, 600, 410);
        chk("relock_state", 32'(trk_state), 2);
        vsync();
        chk("miss_first_edge", 32'(trk_state), 2);
        vsync();
        chk("miss_second_edge", 32'(trk_state), 3);
        result(302, 402, 602, 412);
        chk("miss_recover", 32'(trk_state), 2);
        chk_roi("miss_recover_roi", 301, 401, 601, 411);
        vsync();
        vsync();
        vsync();
        chk("coast_miss2_state", 32'(trk_state), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(trk_state), 0);
        chk("async_rst_valid", 32'(roi_valid), 0);
        chk("async_rst_lock", 32'(lock_cnt), 0);
        chk_roi("async_rst_roi", 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        vsync();
        chk("post_rst_state", 32'(trk_state), 0);
        chk("post_rst_lost", 32'(track_lost), 0);
        frame(300, 400, 420, 410);
        chk("sep120_state", 32'(trk_state), 0);
        frame(300, 400, 600, 410);
        chk("acq_state", 32'(trk_state), 1);
        frame(400, 400, 700, 410);
        chk("jump_state", 32'(trk_state), 1);
        chk("jump_cnt", 32'(lock_cnt), 1);
        frame(400, 400, 700, 410);
        chk("jump_follow_cnt", 32'(lock_cnt), 2);
        frame(400, 400, 700, 410);
        chk("jump_lock_state", 32'(trk_state), 2);
        chk_roi("jump_lock_roi", 400, 400, 700, 410);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
